hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline hazard controller in the ID stage of the 5-stage MIPS pipeline.
- Detects load-use and branch-operand hazards, and holds the PC and IF/ID register for a counted number of stall cycles.
- Drives CtrlZeroSel, the select of the 1-bit 2:1 control muxes: 0 passes the ID control bits, 1 injects a zero bubble into ID/EX.
- Also flushes IF/ID on a taken branch or a jump.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MAX_STALL, 2, largest stall count the counter must hold. Counter width is clog2(MAX_STALL+1).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- ID_Rs  input  REG_ADDR_W  rs field of the instruction in ID.
- ID_Rt  input  REG_ADDR_W  rt field of the instruction in ID.
- ID_UsesRs  input  1  instruction in ID reads rs.
- ID_UsesRt  input  1  instruction in ID reads rt.
- ID_Branch  input  1  instruction in ID is a conditional branch; operands are compared in ID.
- ID_BranchTaken  input  1  branch comparison result is "taken".
- ID_Jump  input  1  instruction in ID is j, jal or jr.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_RegWrite  input  1  instruction in EX writes a register.
- EX_WriteReg  input  REG_ADDR_W  destination register of the instruction in EX.
- MEM_MemRead  input  1  instruction in MEM is a load.
- MEM_WriteReg  input  REG_ADDR_W  destination register of the instruction in MEM.
- PCWrite  output  1  1 = PC may update.
- IFIDWrite  output  1  1 = IF/ID may load.
- CtrlZeroSel  output  1  select for the control-bubble muxes.
- IFIDFlush  output  1  1 = IF/ID clears to a nop on the next edge.

Behaviour:
- Match rule. matchEX = EX_WriteReg!=0 and ((ID_UsesRs and ID_Rs==EX_WriteReg) or (ID_UsesRt and ID_Rt==EX_WriteReg)). matchMEM is the same with MEM_WriteReg. Register 0 never matches.
- Required stall count n, evaluated in RUN only:
  - ID_Branch and EX_MemRead and matchEX -> n=2.
  - else ID_Branch and EX_RegWrite and matchEX -> n=1.
  - else ID_Branch and MEM_MemRead and matchMEM -> n=1.
  - else EX_MemRead and matchEX (load-use) -> n=1.
  - else n=0.
- States: RUN and STALL. Counter cnt is reset to 0.
- RUN, n=0: PCWrite=1, IFIDWrite=1, CtrlZeroSel=0. Stay in RUN.
- RUN, n>=1: PCWrite=0, IFIDWrite=0, CtrlZeroSel=1 in the same cycle (Mealy, zero latency).
  - n=1: stay in RUN; the hazard is re-evaluated next cycle.
  - n>=2: go to STALL with cnt=n-1.
- STALL: PCWrite=0, IFIDWrite=0, CtrlZeroSel=1, and inputs are ignored. cnt decrements each cycle; when cnt==1, go to RUN with cnt=0. For example, n=2 gives exactly 2 consecutive bubble cycles.
- Flush: IFIDFlush=1 iff state==RUN and n==0 and (ID_Jump or (ID_Branch and ID_BranchTaken)).
  - A stall has priority: there is no flush while any stall is asserted. The branch is re-evaluated once its operands are ready.
  - A flush does not affect PCWrite; the PC loads the target.
- Reset (Rst=0) forces, immediately and asynchronously:
  - state=RUN, cnt=0.
  - PCWrite=0, IFIDWrite=0, CtrlZeroSel=1, IFIDFlush=0.
  - This holds even in the middle of STALL.
  - After Rst deasserts, the first edge evaluates from RUN normally.
- X-safety: with all inputs 0 the outputs are 1,1,0,0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds 32-bit outputs StallCount and FlushCount.
  - StallCount increments on every cycle with CtrlZeroSel=1 while Rst=1.
  - FlushCount increments on every cycle with IFIDFlush=1.
  - Both saturate at 32'hFFFFFFFF and clear to 0 on reset.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_UsesRs=1, ID_Rs=8 for one cycle, then the hazard clears -> exactly 1 cycle of PCWrite=0, IFIDWrite=0, CtrlZeroSel=1, then 1,1,0.
- Branch after load: ID_Branch=1, EX_MemRead=1, EX_WriteReg=9, ID_Rt=9, ID_UsesRt=1, with inputs changed to zero in cycle 2 -> stall held for exactly 2 cycles (STALL ignores inputs), IFIDFlush=0 throughout.
- Register zero: EX_MemRead=1, EX_WriteReg=0, ID_Rs=0, ID_UsesRs=1 -> no stall, outputs 1,1,0,0.
- Branch-taken flush: ID_Branch=1, ID_BranchTaken=1, no matches -> IFIDFlush=1, PCWrite=1 in the same cycle. Repeat with ID_Jump=1 -> same. Repeat with matchEX and EX_RegWrite=1 -> IFIDFlush=0, stall 1.
- Reset mid-stall: enter STALL (n=2), drop Rst asynchronously between edges -> outputs go to 0,0,1,0 before the next edge. After release, with no hazard -> 1,1,0,0 on the first cycle.
- HAZARD_STATS_EN: run the load-use, branch-after-load and flush sequences -> StallCount=3, FlushCount=1. Reset -> both 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Purpose : ID-stage hazard controller; stalls PC and IF/ID on load-use / branch-operand hazards, flushes IF/ID on taken branch or jump.
// Latency : outputs are combinational from ID/EX/MEM fields (zero-cycle Mealy); multi-cycle stalls are held by an internal counter.
// Backpress: while stalled PCWrite/IFIDWrite are low and a zero bubble is selected into ID/EX; a stall always beats a flush.
//
// Ports:
//   Clk, Rst                 clock (rising edge), asynchronous active-low reset
//   ID_Rs/ID_Rt/ID_UsesRs/Rt source operands of the instruction in ID
//   ID_Branch/BranchTaken    conditional branch in ID and its resolved outcome
//   ID_Jump                  j / jal / jr in ID
//   EX_MemRead/RegWrite/WriteReg, MEM_MemRead/WriteReg  producers downstream
//   PCWrite, IFIDWrite       hold enables (1 = update)
//   CtrlZeroSel              1 = inject zero control bubble into ID/EX
//   IFIDFlush                1 = clear IF/ID to a nop on the next edge
// Optional: HAZARD_STATS_EN adds saturating 32-bit StallCount / FlushCount outputs.

module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_STALL  = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  ID_Branch,
  input  logic                  ID_BranchTaken,
  input  logic                  ID_Jump,
  input  logic                  EX_MemRead,
  input  logic                  EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] EX_WriteReg,
  input  logic                  MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
`ifdef HAZARD_STATS_EN
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount,
`endif
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  CtrlZeroSel,
  output logic                  IFIDFlush
);

  localparam int CNT_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   need;
  logic               match_ex, match_mem;
  logic               pc_write_c, ifid_write_c, bubble_c, flush_c;

  // Register 0 is hard-wired, so a write to it is never a real dependency.
  assign match_ex  = (EX_WriteReg != '0) &&
                     ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                      (ID_UsesRt && (ID_Rt == EX_WriteReg)));
  assign match_mem = (MEM_WriteReg != '0) &&
                     ((ID_UsesRs && (ID_Rs == MEM_WriteReg)) ||
                      (ID_UsesRt && (ID_Rt == MEM_WriteReg)));

  // Branches compare in ID, so they need the operand one stage earlier than
  // an ALU consumer: a load in EX costs two bubbles, an ALU result in EX or
  // a load in MEM costs one.
  always_comb begin
    need = '0;
    if (ID_Branch && EX_MemRead && match_ex)       need = CNT_W'(2);
    else if (ID_Branch && EX_RegWrite && match_ex) need = CNT_W'(1);
    else if (ID_Branch && MEM_MemRead && match_mem) need = CNT_W'(1);
    else if (EX_MemRead && match_ex)               need = CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    case (state)
      RUN: begin
        if (need != '0) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          bubble_c     = 1'b1;
          // A single bubble stays in RUN: the hazard is simply re-evaluated
          // next cycle with the producer one stage further along.
          if (need > CNT_W'(1)) begin
            state_nxt = STALL;
            cnt_nxt   = need - CNT_W'(1);
          end
        end else begin
          flush_c = ID_Jump || (ID_Branch && ID_BranchTaken);
        end
      end
      STALL: begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        bubble_c     = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset overrides the outputs combinationally so the pipeline is held
  // the instant Rst drops, not at the next edge.
  assign PCWrite     = Rst & pc_write_c;
  assign IFIDWrite   = Rst & ifid_write_c;
  assign CtrlZeroSel = ~Rst | bubble_c;
  assign IFIDFlush   = Rst & flush_c;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (CtrlZeroSel && (StallCount != 32'hFFFF_FFFF)) StallCount <= StallCount + 32'd1;
      if (IFIDFlush && (FlushCount != 32'hFFFF_FFFF))   FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic       Clk;
  logic       Rst;
  logic [4:0] ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
  logic       ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic       EX_MemRead, EX_RegWrite, MEM_MemRead;
  logic       PCWrite, IFIDWrite, CtrlZeroSel, IFIDFlush;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int compared = 0;
  int mismatched = 0;

  hazard_stall_unit #(.REG_ADDR_W(5), .MAX_STALL(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
`ifdef HAZARD_STATS_EN
    .StallCount(StallCount), .FlushCount(FlushCount),
`endif
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .CtrlZeroSel(CtrlZeroSel), .IFIDFlush(IFIDFlush)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {PCWrite, IFIDWrite, CtrlZeroSel, IFIDFlush};
  endfunction

  // ---------------- reference model ----------------
  // Bubbles still owed from an earlier multi-cycle hazard, plus event totals.
  int          m_left = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  function automatic int stall_needed();
    bit mex, mmem;
    mex  = (EX_WriteReg != 0) && ((ID_UsesRs && ID_Rs == EX_WriteReg) ||
                                  (ID_UsesRt && ID_Rt == EX_WriteReg));
    mmem = (MEM_WriteReg != 0) && ((ID_UsesRs && ID_Rs == MEM_WriteReg) ||
                                   (ID_UsesRt && ID_Rt == MEM_WriteReg));
    if (ID_Branch && EX_MemRead && mex)   return 2;
    if (ID_Branch && EX_RegWrite && mex)  return 1;
    if (ID_Branch && MEM_MemRead && mmem) return 1;
    if (EX_MemRead && mex)                return 1;
    return 0;
  endfunction

  always @(negedge Rst) begin
    m_left  = 0;
    m_stall = 0;
    m_flush = 0;
  end

  always @(negedge Clk) begin
    logic [3:0] exp;
    int n;
    if (!Rst) begin
      exp = 4'b0010;
      m_left = 0;
    end else if (m_left > 0) begin
      exp = 4'b0010;
      m_left--;
    end else begin
      n = stall_needed();
      if (n > 0) begin
        exp = 4'b0010;
        m_left = n - 1;
      end else begin
        exp = {3'b110, (ID_Jump || (ID_Branch && ID_BranchTaken))};
      end
    end
    check("cycle_outputs", {28'd0, outs()}, {28'd0, exp});
`ifdef HAZARD_STATS_EN
    check("stall_count", StallCount, m_stall);
    check("flush_count", FlushCount, m_flush);
`endif
    if (Rst && exp[1]) m_stall++;
    if (Rst && exp[0]) m_flush++;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    ID_Branch = 0; ID_BranchTaken = 0; ID_Jump = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
    MEM_MemRead = 0; MEM_WriteReg = 0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_branch_after_load();
    idle();
    ID_Branch = 1; EX_MemRead = 1; EX_WriteReg = 9; ID_Rt = 9; ID_UsesRt = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 0;
    idle();
    #3;
    check("reset_out", {28'd0, outs()}, 32'h2);
    cyc();
    cyc();
    Rst = 1;
    #2 check("x_safe_idle", {28'd0, outs()}, 32'hC);

    // load-use, one bubble then free-running
    cyc();
    EX_MemRead = 1; EX_WriteReg = 8; ID_UsesRs = 1; ID_Rs = 8;
    #2 check("loaduse_c0", {28'd0, outs()}, 32'h2);
    cyc(); idle();
    #2 check("loaduse_c1", {28'd0, outs()}, 32'hC);

    // branch after load, inputs cleared in the second cycle
    cyc(); set_branch_after_load();
    #2 check("bal_c0", {28'd0, outs()}, 32'h2);
    cyc(); idle();
    #2 check("bal_c1_ignores_inputs", {28'd0, outs()}, 32'h2);
    cyc();
    #2 check("bal_c2", {28'd0, outs()}, 32'hC);

    // register zero never matches
    cyc();
    EX_MemRead = 1; EX_WriteReg = 0; ID_Rs = 0; ID_UsesRs = 1;
    #2 check("reg_zero", {28'd0, outs()}, 32'hC);

    // taken branch flush
    cyc(); idle(); ID_Branch = 1; ID_BranchTaken = 1;
    #2 check("branch_flush", {28'd0, outs()}, 32'hD);
    cyc(); idle();
`ifdef HAZARD_STATS_EN
    #2;
    check("stats_stall_3", StallCount, 32'd3);
    check("stats_flush_1", FlushCount, 32'd1);
`endif
    cyc(); ID_Jump = 1;
    #2 check("jump_flush", {28'd0, outs()}, 32'hD);
    cyc(); idle();
    ID_Branch = 1; ID_BranchTaken = 1; EX_RegWrite = 1; EX_WriteReg = 5; ID_Rs = 5; ID_UsesRs = 1;
    #2 check("branch_stall_beats_flush", {28'd0, outs()}, 32'h2);
    cyc(); idle();
    #2 check("after_branch_stall", {28'd0, outs()}, 32'hC);

    // asynchronous reset in the middle of STALL
    cyc(); set_branch_after_load();
    cyc(); idle();
    #1 Rst = 0;
    #1 check("rst_async_mid_stall", {28'd0, outs()}, 32'h2);
`ifdef HAZARD_STATS_EN
    check("rst_stall_cnt", StallCount, 32'd0);
    check("rst_flush_cnt", FlushCount, 32'd0);
`endif
    cyc();
    Rst = 1;
    #2 check("rst_release", {28'd0, outs()}, 32'hC);

    // randomized traffic with occasional reset pulses; small register range
    // so that dependencies occur often
    for (int i = 0; i < 3000; i++) begin
      cyc();
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      ID_UsesRs      = 1'($urandom);
      ID_UsesRt      = 1'($urandom);
      ID_Branch      = 1'($urandom);
      ID_BranchTaken = 1'($urandom);
      ID_Jump        = ($urandom_range(0, 7) == 0);
      EX_MemRead     = 1'($urandom);
      EX_RegWrite    = 1'($urandom);
      EX_WriteReg    = 5'($urandom_range(0, 3));
      MEM_MemRead    = 1'($urandom);
      MEM_WriteReg   = 5'($urandom_range(0, 3));
      Rst            = ($urandom_range(0, 99) != 0);
    end
    cyc(); Rst = 1; idle();
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
